image_stream_ram: RTL and testbench

IMAGE_STREAM_RAM -- requirements
Module: image_stream_ram

---
 rtl/image_stream_ram.sv | 154 +++++++++++++++
 tb/tb_image_stream_ram.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_ram.sv
// image_stream_ram: host-loaded single-port RAM replayed as a valid/ready sample stream.
// Define IMAGE_STREAM_EPOCH_EN to add the 16-bit epoch_count output (counts completed passes).
module image_stream_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 785,
  parameter int DEPTH      = 16384
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [ADDR_WIDTH:0]   num_samples,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic [ADDR_WIDTH-1:0] s_index,
  output logic                  s_last,
`ifdef IMAGE_STREAM_EPOCH_EN
  output logic [15:0]           epoch_count,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_NUM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  state_t                r_state;
  logic                  r_busy;
  logic                  r_s_valid;
  logic                  r_s_last;
  logic [ADDR_WIDTH-1:0] r_s_index;
  logic [DATA_WIDTH-1:0] r_s_data;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_num;
  logic                  r_loop;

  logic w_wr_ok;
  logic w_fire;
  logic w_start_ok;
  logic w_rd_issue;
  logic w_at_end;

  assign w_wr_ok    = wr_en && ({1'b0, wr_addr} < LP_DEPTH);
  assign w_fire     = r_s_valid && s_ready;
  assign w_start_ok = start && (num_samples != '0) && (num_samples <= LP_DEPTH);
  // The single port belongs to the host on write cycles, so a pending read waits one cycle.
  assign w_rd_issue = (r_state == ST_STREAM) && (!r_s_valid || s_ready) && !wr_en;
  assign w_at_end   = ({1'b0, r_rd_addr} == (r_num - LP_NUM_ONE));

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // The output register doubles as the RAM read register: 1-cycle read latency, held on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
      r_s_index <= '0;
      r_s_data  <= '0;
      r_rd_addr <= '0;
      r_num     <= '0;
      r_loop    <= 1'b0;
    end else if (stop) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state   <= ST_STREAM;
            r_busy    <= 1'b1;
            r_num     <= num_samples;
            r_loop    <= loop;
            r_rd_addr <= '0;
          end
        end
        ST_STREAM: begin
          if (w_rd_issue) begin
            r_s_data  <= r_mem[r_rd_addr];
            r_s_index <= r_rd_addr;
            r_s_last  <= w_at_end;
            r_s_valid <= 1'b1;
            if (w_at_end) begin
              r_rd_addr <= '0;
              if (!r_loop) begin
                r_state <= ST_DRAIN;
              end
            end else begin
              r_rd_addr <= r_rd_addr + LP_ADDR_ONE;
            end
          end else if (w_fire) begin
            r_s_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_fire) begin
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMAGE_STREAM_EPOCH_EN
  logic [15:0] r_epoch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epoch <= '0;
    end else if (!stop && (r_state == ST_IDLE) && w_start_ok) begin
      r_epoch <= '0;
    end else if (w_fire && r_s_last) begin
      r_epoch <= r_epoch + 16'd1;
    end
  end

  assign epoch_count = r_epoch;
`endif

  assign s_valid = r_s_valid;
  assign s_data  = r_s_data;
  assign s_index = r_s_index;
  assign s_last  = r_s_last;
  assign busy    = r_busy;

endmodule

// File: tb/tb_image_stream_ram.sv
// Self-checking bench for image_stream_ram: randomized host loads and consumer back-pressure
// scored against an array model of the RAM and the index/last pattern of each pass.
module tb_image_stream_ram;
  localparam int AW    = 6;
  localparam int DW    = 40;
  localparam int DEPTH = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic          s_ready = 1'b0;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [AW-1:0] s_index;
  logic          s_last;
  logic          busy;
`ifdef IMAGE_STREAM_EPOCH_EN
  logic [15:0]   epoch_count;
`endif

  image_stream_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .num_samples(num_samples),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_index(s_index), .s_last(s_last),
`ifdef IMAGE_STREAM_EPOCH_EN
    .epoch_count(epoch_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int hold_err = 0;
  logic [DW-1:0] mem_model [DEPTH];
  logic [DW-1:0] got_data [$];
  logic [AW-1:0] got_idx [$];
  bit            got_last [$];
  int            got_cyc [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    mem_model[a] = d;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic pulse_start(input int n, input bit lp);
    start = 1'b1; num_samples = (AW+1)'(n); loop = lp;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Drives s_ready (0: always, 1: random, 2: 1,0,0,1 pattern), records handshakes,
  // counts any change of a stalled sample, and optionally injects one host write.
  task automatic collect(input int want, input int mode, input int budget, input int wr_at,
                         input int wa, input logic [DW-1:0] wd, output bit timeout);
    logic [DW-1:0] hd;
    logic [AW-1:0] hi;
    bit hl;
    bit held;
    bit wrote;
    held = 1'b0; wrote = 1'b0; hd = '0; hi = '0; hl = 1'b0;
    got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    hold_err = 0; timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (held && (s_valid !== 1'b1 || s_data !== hd || s_index !== hi || s_last !== hl))
        hold_err++;
      case (mode)
        0: s_ready = 1'b1;
        1: s_ready = 1'($urandom_range(0, 1));
        default: s_ready = (c % 4 == 0) || (c % 4 == 3);
      endcase
      if (!wrote && got_data.size() == wr_at) begin
        wr_en = 1'b1; wr_addr = AW'(wa); wr_data = wd; wrote = 1'b1;
      end
      if (s_valid === 1'b1 && s_ready) begin
        got_data.push_back(s_data); got_idx.push_back(s_index);
        got_last.push_back(s_last); got_cyc.push_back(c);
      end
      held = (s_valid === 1'b1) && !s_ready;
      hd = s_data; hi = s_index; hl = s_last;
      step();
      wr_en = 1'b0;
      if (got_data.size() >= want) begin
        timeout = 1'b0;
        break;
      end
    end
    s_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_checks++;
    if ({s_valid, s_last, busy} !== 3'b000 || s_index !== '0 || s_data !== '0)
      $display("FAIL reset_outputs: valid=%b last=%b busy=%b idx=%0d data=%h, required all zero",
               s_valid, s_last, busy, s_index, s_data);
    else n_pass++;
`ifdef IMAGE_STREAM_EPOCH_EN
    n_checks++;
    if (epoch_count !== 16'd0) $display("FAIL reset_epoch: got %0d required 0", epoch_count);
    else n_pass++;
`endif
    rst_n = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) host_write(i, rand_word());
  endtask

  task automatic test_basic();
    bit to;
    for (int i = 0; i < 4; i++) host_write(i, DW'(8'hA0 + i));
    pulse_start(4, 1'b0);
    collect(4, 0, 50, -1, 0, '0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL basic_timeout: got %0d handshakes required 4", got_data.size());
    else n_pass++;
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_data[k] !== DW'(8'hA0 + k) || got_last[k] !== (k == 3) ||
          (k > 0 && got_cyc[k] !== got_cyc[k-1] + 1))
        $display("FAIL basic_hs%0d: data=%h last=%b cyc=%0d required data=%h last=%b consecutive",
                 k, got_data[k], got_last[k], got_cyc[k], DW'(8'hA0 + k), (k == 3));
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || s_valid !== 1'b0)
      $display("FAIL basic_end: busy=%b valid=%b required 0 0", busy, s_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit to;
    pulse_start(4, 1'b0);
    collect(4, 2, 80, -1, 0, '0, to);
    n_checks++;
    if (to !== 1'b0 || hold_err !== 0)
      $display("FAIL stall_hold: handshakes=%0d hold_err=%0d required 4 and 0", got_data.size(), hold_err);
    else n_pass++;
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_data[k] !== DW'(8'hA0 + k) || got_idx[k] !== AW'(k))
        $display("FAIL stall_hs%0d: data=%h idx=%0d required data=%h idx=%0d",
                 k, got_data[k], got_idx[k], DW'(8'hA0 + k), k);
      else n_pass++;
    end
    s_ready = 1'b1;
    step(); step();
    n_checks++;
    if (s_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stall_nodup: valid=%b busy=%b required 0 0", s_valid, busy);
    else n_pass++;
    s_ready = 1'b0;
  endtask

  task automatic test_loop();
    bit to;
    pulse_start(3, 1'b1);
    collect(7, 1, 400, -1, 0, '0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL loop_timeout: got %0d handshakes required 7", got_data.size());
    else n_pass++;
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_idx[k] !== AW'(k % 3) || got_last[k] !== (k % 3 == 2) || got_data[k] !== mem_model[k % 3])
        $display("FAIL loop_hs%0d: idx=%0d last=%b data=%h required idx=%0d last=%b data=%h",
                 k, got_idx[k], got_last[k], got_data[k], k % 3, (k % 3 == 2), mem_model[k % 3]);
      else n_pass++;
    end
`ifdef IMAGE_STREAM_EPOCH_EN
    n_checks++;
    if (epoch_count !== 16'd2) $display("FAIL loop_epoch: got %0d required 2", epoch_count);
    else n_pass++;
`endif
    n_checks++;
    if (busy !== 1'b1) $display("FAIL loop_busy: got %b required 1", busy);
    else n_pass++;
    pulse_stop();
    n_checks++;
    if (s_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL loop_stop: valid=%b busy=%b required 0 0", s_valid, busy);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    bit to;
    pulse_start(0, 1'b0);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL start_zero: busy=%b required 0", busy);
    else n_pass++;
    pulse_start(DEPTH + 1, 1'b0);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL start_over_depth: busy=%b required 0", busy);
    else n_pass++;
    pulse_start(5, 1'b0);
`ifdef IMAGE_STREAM_EPOCH_EN
    n_checks++;
    if (epoch_count !== 16'd0) $display("FAIL epoch_clear: got %0d required 0", epoch_count);
    else n_pass++;
`endif
    pulse_start(2, 1'b1);
    collect(5, 0, 60, -1, 0, '0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL busy_start_timeout: got %0d handshakes required 5", got_data.size());
    else n_pass++;
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_idx[k] !== AW'(k) || got_last[k] !== (k == 4))
        $display("FAIL busy_start_hs%0d: idx=%0d last=%b required idx=%0d last=%b",
                 k, got_idx[k], got_last[k], k, (k == 4));
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_start_end: busy=%b required 0", busy);
    else n_pass++;
    pulse_start(DEPTH, 1'b0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL start_full_depth: busy=%b required 1", busy);
    else n_pass++;
    pulse_stop();
  endtask

  task automatic test_write_bubble();
    bit to;
    int gaps;
    logic [DW-1:0] nd;
    nd = rand_word();
    pulse_start(20, 1'b0);
    collect(20, 0, 100, 12, 9, nd, to);
    gaps = 0;
    for (int k = 1; k < got_cyc.size(); k++) gaps += got_cyc[k] - got_cyc[k-1] - 1;
    n_checks++;
    if (to !== 1'b0 || gaps !== 1)
      $display("FAIL bubble_gaps: handshakes=%0d gaps=%0d required 20 and 1", got_data.size(), gaps);
    else n_pass++;
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_data[k] !== mem_model[k] || got_idx[k] !== AW'(k))
        $display("FAIL bubble_hs%0d: data=%h idx=%0d required data=%h idx=%0d",
                 k, got_data[k], got_idx[k], mem_model[k], k);
      else n_pass++;
    end
    mem_model[9] = nd;
    pulse_start(10, 1'b0);
    collect(10, 1, 200, -1, 0, '0, to);
    n_checks++;
    if (to !== 1'b0 || got_data[9] !== nd)
      $display("FAIL bubble_readback: handshakes=%0d data=%h required 10 and %h",
               got_data.size(), (got_data.size() > 9) ? got_data[9] : '0, nd);
    else n_pass++;
  endtask

  task automatic test_stop();
    bit to;
    pulse_start(20, 1'b0);
    collect(5, 0, 60, -1, 0, '0, to);
    stop = 1'b1; start = 1'b1; num_samples = (AW+1)'(4); loop = 1'b0;
    step();
    stop = 1'b0; start = 1'b0;
    n_checks++;
    if (s_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stop_start_next: valid=%b busy=%b required 0 0", s_valid, busy);
    else n_pass++;
    s_ready = 1'b1;
    step(); step(); step();
    n_checks++;
    if (s_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stop_stays_idle: valid=%b busy=%b required 0 0", s_valid, busy);
    else n_pass++;
    s_ready = 1'b0;
  endtask

  task automatic test_random();
    bit to;
    int n;
    int want;
    bit lp;
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 8; w++) host_write($urandom_range(0, DEPTH - 1), rand_word());
      n = $urandom_range(1, DEPTH);
      lp = 1'($urandom_range(0, 1));
      want = lp ? 2 * n + 1 : n;
      pulse_start(n, lp);
      collect(want, 1, 1500, -1, 0, '0, to);
      n_checks++;
      if (to !== 1'b0 || hold_err !== 0)
        $display("FAIL rand%0d_flow: handshakes=%0d hold_err=%0d required %0d and 0",
                 it, got_data.size(), hold_err, want);
      else n_pass++;
      for (int k = 0; k < got_data.size(); k++) begin
        n_checks++;
        if (got_idx[k] !== AW'(k % n) || got_last[k] !== (k % n == n - 1) || got_data[k] !== mem_model[k % n])
          $display("FAIL rand%0d_hs%0d: idx=%0d last=%b data=%h required idx=%0d last=%b data=%h",
                   it, k, got_idx[k], got_last[k], got_data[k], k % n, (k % n == n - 1), mem_model[k % n]);
        else n_pass++;
      end
      if (lp) pulse_stop();
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rand%0d_end: busy=%b required 0", it, busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    bit to;
    pulse_start(16, 1'b0);
    collect(3, 0, 40, -1, 0, '0, to);
    s_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (s_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL async_reset_now: valid=%b busy=%b required 0 0", s_valid, busy);
    else n_pass++;
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (s_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL async_reset_after: valid=%b busy=%b required 0 0", s_valid, busy);
    else n_pass++;
    pulse_start(16, 1'b0);
    collect(16, 1, 400, -1, 0, '0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL reset_readback_timeout: got %0d handshakes required 16", got_data.size());
    else n_pass++;
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_data[k] !== mem_model[k])
        $display("FAIL reset_readback%0d: data=%h required %h", k, got_data[k], mem_model[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_loop();
    test_ignored_start();
    test_write_bubble();
    test_stop();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
